// File: rtl/axi_rm_pkg.sv
// Shared definitions for the round-robin AXI read master: descriptor layout,
// response codes and the AR state encoding.
package axi_rm_pkg;

    localparam int PROT_LSB  = 0;
    localparam int PROT_W    = 3;
    localparam int CACHE_LSB = 3;
    localparam int CACHE_W   = 4;
    localparam int LOCK_LSB  = 7;
    localparam int LOCK_W    = 2;
    localparam int BURST_LSB = 9;
    localparam int BURST_W   = 2;
    localparam int SIZE_LSB  = 11;
    localparam int SIZE_W    = 2;
    localparam int LEN_LSB   = 13;
    localparam int LEN_W     = 4;
    localparam int ADDR_LSB  = 17;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic {
        AR_IDLE,
        AR_ISSUE
    } ar_state_t;

    // Descriptor is {id, addr, len, size, burst, lock, cache, prot}.
    function automatic int req_w(input int bus_width, input int tag_bits);
        return tag_bits + bus_width + ADDR_LSB;
    endfunction

    function automatic int id_lsb(input int bus_width);
        return ADDR_LSB + bus_width;
    endfunction

endpackage

// File: rtl/axi_read_master_rr_req_fifo.sv
// Show-ahead request FIFO; head entry is visible on rdata whenever not empty.
module req_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             wr,
    input  logic [Width-1:0] wdata,
    input  logic             rd,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    // A pop frees the slot in the same cycle, so push-on-full is legal then.
    assign push  = wr && (!full || rd);
    assign pop   = rd && !empty;
    assign full  = (count == CW'(Depth));
    assign empty = (count == '0);
    assign rdata = mem[rptr];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/axi_read_master_rr.sv
// AXI3 read master: round-robin AR issue from per-source request FIFOs,
// per-ID burst tracking and a one-entry registered R output stage.
//   state    | meaning
//   AR_IDLE  | scanning sources from rr_ptr for an eligible head
//   AR_ISSUE | AR payload registered, ARVALID held until ARREADY
module axi_read_master_rr
    import axi_rm_pkg::*;
#(
    parameter int BusWidth       = 32,
    parameter int tagbits        = 2,
    parameter int NumSrc         = 2,
    parameter int FifoDepth      = 4,
    parameter int MaxOutstanding = 4,
    localparam int ReqW = req_w(BusWidth, tagbits),
    localparam int OW   = $clog2(MaxOutstanding + 1)
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic [NumSrc-1:0]      req_wr,
    input  logic [NumSrc*ReqW-1:0] req_in,
    output logic [NumSrc-1:0]      req_full,
    output logic [tagbits-1:0]     ARID,
    output logic [BusWidth-1:0]    ARADDR,
    output logic [3:0]             ARLEN,
    output logic [1:0]             ARSIZE,
    output logic [1:0]             ARBURST,
    output logic [1:0]             ARLOCK,
    output logic [3:0]             ARCACHE,
    output logic [2:0]             ARPROT,
    output logic                   ARVALID,
    input  logic                   ARREADY,
    input  logic [tagbits-1:0]     RID,
    input  logic [BusWidth-1:0]    RDATA,
    input  logic [1:0]             RRESP,
    input  logic                   RLAST,
    input  logic                   RVALID,
    output logic                   RREADY,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [BusWidth-1:0]    rd_data,
    output logic [tagbits-1:0]     rd_id,
    output logic                   rd_last,
    output logic                   rd_err,
    output logic [OW-1:0]          outstanding
);
    localparam int NumId = 1 << tagbits;
    localparam int SW    = (NumSrc > 1) ? $clog2(NumSrc) : 1;
    localparam int IdLsb = id_lsb(BusWidth);

    logic [ReqW-1:0]   head [NumSrc];
    logic [NumSrc-1:0] fifo_empty;
    logic [NumSrc-1:0] fifo_pop;
    logic [NumSrc-1:0] elig;
    ar_state_t         state_q, state_d;
    logic [SW-1:0]     rr_ptr, gnt_q, gnt_idx, cand;
    logic              gnt_vld, grant, ar_acc, cap_ok;
    logic [NumId-1:0]  busy;
    logic [3:0]        exp_len  [NumId];
    logic [3:0]        beat_cnt [NumId];
    logic              r_hs, r_done, r_err_c;

    for (genvar g = 0; g < NumSrc; g++) begin : g_src
        req_fifo #(.Width(ReqW), .Depth(FifoDepth)) u_fifo (
            .ACLK    (ACLK),
            .ARESETn (ARESETn),
            .wr      (req_wr[g]),
            .wdata   (req_in[g*ReqW +: ReqW]),
            .rd      (fifo_pop[g]),
            .rdata   (head[g]),
            .full    (req_full[g]),
            .empty   (fifo_empty[g])
        );
    end

    assign cap_ok = (outstanding < OW'(MaxOutstanding));

    always_comb begin
        elig    = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = rr_ptr;
        for (int i = 0; i < NumSrc; i++) begin
            elig[i] = !fifo_empty[i] && !busy[head[i][IdLsb +: tagbits]];
        end
        for (int k = 0; k < NumSrc; k++) begin
            if (!gnt_vld && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
            cand = (cand == SW'(NumSrc - 1)) ? '0 : cand + 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state_q <= AR_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        ar_acc   = 1'b0;
        fifo_pop = '0;
        case (state_q)
            AR_IDLE: begin
                if (gnt_vld && cap_ok) begin
                    grant             = 1'b1;
                    fifo_pop[gnt_idx] = 1'b1;
                    state_d           = AR_ISSUE;
                end
            end
            AR_ISSUE: begin
                if (ARREADY) begin
                    ar_acc  = 1'b1;
                    state_d = AR_IDLE;
                end
            end
            default: state_d = AR_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ARVALID <= 1'b0;
            ARID    <= '0;
            ARADDR  <= '0;
            ARLEN   <= '0;
            ARSIZE  <= '0;
            ARBURST <= '0;
            ARLOCK  <= '0;
            ARCACHE <= '0;
            ARPROT  <= '0;
            gnt_q   <= '0;
            rr_ptr  <= '0;
        end else if (grant) begin
            ARVALID <= 1'b1;
            ARID    <= head[gnt_idx][IdLsb +: tagbits];
            ARADDR  <= head[gnt_idx][ADDR_LSB +: BusWidth];
            ARLEN   <= head[gnt_idx][LEN_LSB +: LEN_W];
            ARSIZE  <= head[gnt_idx][SIZE_LSB +: SIZE_W];
            ARBURST <= head[gnt_idx][BURST_LSB +: BURST_W];
            ARLOCK  <= head[gnt_idx][LOCK_LSB +: LOCK_W];
            ARCACHE <= head[gnt_idx][CACHE_LSB +: CACHE_W];
            ARPROT  <= head[gnt_idx][PROT_LSB +: PROT_W];
            gnt_q   <= gnt_idx;
        end else if (ar_acc) begin
            ARVALID <= 1'b0;
            rr_ptr  <= (gnt_q == SW'(NumSrc - 1)) ? '0 : gnt_q + 1'b1;
        end
    end

    // Gated by reset so every output reads 0 while ARESETn is low.
    assign RREADY  = ARESETn && (!rd_valid || rd_ready);
    assign r_hs    = RVALID && RREADY;
    assign r_done  = r_hs && RLAST && busy[RID];
    assign r_err_c = (RRESP != RESP_OKAY) || !busy[RID]
                   || (RLAST && (beat_cnt[RID] != exp_len[RID]))
                   || (!RLAST && (beat_cnt[RID] == exp_len[RID]));

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_id    <= '0;
            rd_last  <= 1'b0;
            rd_err   <= 1'b0;
        end else if (r_hs) begin
            rd_valid <= 1'b1;
            rd_data  <= RDATA;
            rd_id    <= RID;
            rd_last  <= RLAST;
            rd_err   <= r_err_c;
        end else if (rd_ready) begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end
    end

    // Completion is written before the new issue so a reused ID ends up busy.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            busy        <= '0;
            outstanding <= '0;
            for (int i = 0; i < NumId; i++) begin
                exp_len[i]  <= '0;
                beat_cnt[i] <= '0;
            end
        end else begin
            if (r_hs) begin
                beat_cnt[RID] <= beat_cnt[RID] + 1'b1;
                if (RLAST) busy[RID] <= 1'b0;
            end
            if (ar_acc) begin
                busy[ARID]     <= 1'b1;
                exp_len[ARID]  <= ARLEN;
                beat_cnt[ARID] <= '0;
            end
            outstanding <= outstanding + OW'(ar_acc) - OW'(r_done);
        end
    end

endmodule

// File: tb/tb_axi_read_master_rr.sv
// Scoreboard bench for axi_read_master_rr: expected AR requests and R beats
// are queued as stimulus is driven and popped when the DUT presents them.
module tb_axi_read_master_rr;
    import axi_rm_pkg::*;

    localparam int BW = 32;
    localparam int TB = 2;
    localparam int NS = 2;
    localparam int FD = 4;
    localparam int MO = 4;
    localparam int RW = req_w(BW, TB);
    localparam int OW = $clog2(MO + 1);

    logic              ACLK, ARESETn;
    logic [NS-1:0]     req_wr;
    logic [NS*RW-1:0]  req_in;
    logic [NS-1:0]     req_full;
    logic [TB-1:0]     ARID;
    logic [BW-1:0]     ARADDR;
    logic [3:0]        ARLEN;
    logic [1:0]        ARSIZE, ARBURST, ARLOCK;
    logic [3:0]        ARCACHE;
    logic [2:0]        ARPROT;
    logic              ARVALID, ARREADY;
    logic [TB-1:0]     RID;
    logic [BW-1:0]     RDATA;
    logic [1:0]        RRESP;
    logic              RLAST, RVALID, RREADY;
    logic              rd_valid, rd_ready;
    logic [BW-1:0]     rd_data;
    logic [TB-1:0]     rd_id;
    logic              rd_last, rd_err;
    logic [OW-1:0]     outstanding;

    axi_read_master_rr #(
        .BusWidth(BW), .tagbits(TB), .NumSrc(NS), .FifoDepth(FD), .MaxOutstanding(MO)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .req_wr(req_wr), .req_in(req_in), .req_full(req_full),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_id(rd_id),
        .rd_last(rd_last), .rd_err(rd_err), .outstanding(outstanding)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [TB-1:0] id;
        logic [BW-1:0] addr;
        logic [3:0]    len;
    } ar_exp_t;

    typedef struct {
        logic [BW-1:0] data;
        logic [TB-1:0] id;
        logic          last;
        logic          err;
    } rd_exp_t;

    ar_exp_t ar_q[$];
    rd_exp_t rd_q[$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] mk_req(input logic [TB-1:0] id, input logic [BW-1:0] addr,
                                             input logic [3:0] len);
        return {id, addr, len, 2'd2, 2'd1, 2'd0, 4'd0, 3'd0};
    endfunction

    always @(negedge ACLK) begin : mon
        ar_exp_t ea;
        rd_exp_t er;
        if (ARESETn && ARVALID && ARREADY) begin
            if (ar_q.size() == 0) chk("ar_unexpected", 1, 0);
            else begin
                ea = ar_q.pop_front();
                chk("ar_id",    ARID,   ea.id);
                chk("ar_addr",  ARADDR, ea.addr);
                chk("ar_len",   ARLEN,  ea.len);
                chk("ar_size",  ARSIZE, 2);
                chk("ar_burst", ARBURST, 1);
            end
        end
        if (ARESETn && rd_valid && rd_ready) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                er = rd_q.pop_front();
                chk("rd_data", rd_data, er.data);
                chk("rd_id",   rd_id,   er.id);
                chk("rd_last", rd_last, er.last);
                chk("rd_err",  rd_err,  er.err);
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic push(input logic [NS-1:0] mask, input logic [RW-1:0] d0, input logic [RW-1:0] d1);
        req_wr = mask;
        req_in = {d1, d0};
        tick();
        req_wr = '0;
    endtask

    task automatic exp_ar(input logic [TB-1:0] id, input logic [BW-1:0] addr, input logic [3:0] len);
        ar_exp_t e;
        e.id = id; e.addr = addr; e.len = len;
        ar_q.push_back(e);
    endtask

    task automatic wait_ar();
        for (int i = 0; i < 200 && ar_q.size() != 0; i++) tick();
        chk("ar_drain", ar_q.size(), 0);
    endtask

    task automatic r_beat(input logic [TB-1:0] id, input logic [1:0] resp, input logic last,
                          input logic err);
        rd_exp_t e;
        RVALID = 1'b1; RID = id; RDATA = $urandom; RRESP = resp; RLAST = last;
        for (int i = 0; i < 100 && !RREADY; i++) tick();
        chk("r_accept", RREADY, 1);
        e.data = RDATA; e.id = id; e.last = last; e.err = err;
        if (RREADY) rd_q.push_back(e);
        tick();
        RVALID = 1'b0; RLAST = 1'b0;
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        ar_q.delete();
        rd_q.delete();
        #20;
        @(posedge ACLK);
        #1 ARESETn = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seen;
        int bad;
        ARESETn = 1'b0; req_wr = '0; req_in = '0; ARREADY = 1'b0;
        RID = '0; RDATA = '0; RRESP = RESP_OKAY; RLAST = 1'b0; RVALID = 1'b0; rd_ready = 1'b1;
        #12;
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_rready", RREADY, 0);
        chk("rst_req_full", req_full, 0);
        @(posedge ACLK);
        #1 ARESETn = 1'b1;
        tick();

        // single 4-beat burst, exact AR latency
        ARREADY = 1'b1;
        exp_ar(1, 32'h100, 3);
        push(2'b01, mk_req(1, 32'h100, 3), '0);
        @(negedge ACLK); chk("t1_arvalid_early", ARVALID, 0);
        @(negedge ACLK); chk("t1_arvalid", ARVALID, 1);
        tick();
        wait_ar();
        chk("t1_outstanding_1", outstanding, 1);
        for (int b = 0; b < 4; b++) r_beat(1, RESP_OKAY, b == 3, 0);
        tick(3);
        chk("t1_outstanding_0", outstanding, 0);
        chk("t1_rd_drain", rd_q.size(), 0);

        // round robin from rr_ptr=0, then busy/cap block
        do_reset();
        ARREADY = 1'b1;
        exp_ar(0, 32'h1000, 0); exp_ar(2, 32'h2000, 0);
        exp_ar(1, 32'h1100, 0); exp_ar(3, 32'h2100, 0);
        push(2'b11, mk_req(0, 32'h1000, 0), mk_req(2, 32'h2000, 0));
        push(2'b11, mk_req(1, 32'h1100, 0), mk_req(3, 32'h2100, 0));
        wait_ar();
        chk("t2_outstanding_4", outstanding, 4);
        push(2'b01, mk_req(0, 32'h1200, 0), '0);
        seen = 0;
        repeat (8) begin
            @(negedge ACLK);
            if (ARVALID) seen++;
        end
        tick();
        chk("t2_blocked_cycles", seen, 0);
        exp_ar(0, 32'h1200, 0);
        r_beat(0, RESP_OKAY, 1, 0);
        wait_ar();
        chk("t2_outstanding_refill", outstanding, 4);
        r_beat(2, RESP_OKAY, 1, 0);
        r_beat(1, RESP_OKAY, 1, 0);
        r_beat(3, RESP_OKAY, 1, 0);
        r_beat(0, RESP_OKAY, 1, 0);
        tick(3);
        chk("t2_outstanding_0", outstanding, 0);

        // AR held stable under backpressure
        ARREADY = 1'b0;
        exp_ar(2, 32'h2A0, 1);
        push(2'b10, '0, mk_req(2, 32'h2A0, 1));
        for (int i = 0; i < 20 && !ARVALID; i++) tick();
        bad = 0;
        repeat (5) begin
            @(negedge ACLK);
            if (!ARVALID || ARADDR !== 32'h2A0 || ARID !== 2'd2 || ARLEN !== 4'd1) bad++;
        end
        tick();
        chk("t3_hold_violations", bad, 0);
        chk("t3_ar_pending", ar_q.size(), 1);
        ARREADY = 1'b1;
        wait_ar();

        // busy head on src0 must not block src1
        push(2'b11, mk_req(2, 32'h300, 0), mk_req(3, 32'h400, 0));
        exp_ar(3, 32'h400, 0);
        wait_ar();
        tick(3);
        chk("t4_conflict_hold", ARVALID, 0);
        chk("t4_outstanding_2", outstanding, 2);
        exp_ar(2, 32'h300, 0);
        r_beat(2, RESP_OKAY, 0, 0);
        r_beat(2, RESP_OKAY, 1, 0);
        wait_ar();
        r_beat(3, RESP_OKAY, 1, 0);
        r_beat(2, RESP_OKAY, 1, 0);
        tick(3);
        chk("t4_outstanding_0", outstanding, 0);

        // error cases
        exp_ar(1, 32'h500, 3);
        push(2'b01, mk_req(1, 32'h500, 3), '0);
        wait_ar();
        r_beat(1, RESP_OKAY, 0, 0);
        r_beat(1, RESP_OKAY, 1, 1);
        tick(2);
        chk("t5_early_last_outstanding", outstanding, 0);
        exp_ar(1, 32'h540, 1);
        push(2'b01, mk_req(1, 32'h540, 1), '0);
        wait_ar();
        r_beat(1, RESP_SLVERR, 0, 1);
        r_beat(1, RESP_OKAY, 1, 0);
        r_beat(3, RESP_OKAY, 0, 1);
        exp_ar(0, 32'h580, 0);
        push(2'b01, mk_req(0, 32'h580, 0), '0);
        wait_ar();
        r_beat(0, RESP_OKAY, 0, 1);
        r_beat(0, RESP_OKAY, 1, 1);
        tick(3);
        chk("t5_outstanding_0", outstanding, 0);
        chk("t5_rd_drain", rd_q.size(), 0);

        // reset mid-burst
        exp_ar(1, 32'h600, 3);
        push(2'b01, mk_req(1, 32'h600, 3), '0);
        wait_ar();
        rd_ready = 1'b0;
        r_beat(1, RESP_OKAY, 0, 0);
        ARREADY = 1'b0;
        push(2'b10, '0, mk_req(2, 32'h640, 0));
        for (int i = 0; i < 20 && !ARVALID; i++) tick();
        RVALID = 1'b1; RID = 2'd1; RDATA = 32'hDEAD_BEEF; RLAST = 1'b0;
        chk("t6_pre_arvalid", ARVALID, 1);
        chk("t6_pre_rd_valid", rd_valid, 1);
        chk("t6_pre_outstanding", outstanding, 1);
        #2 ARESETn = 1'b0;
        #1;
        chk("t6_rst_arvalid", ARVALID, 0);
        chk("t6_rst_rd_valid", rd_valid, 0);
        chk("t6_rst_outstanding", outstanding, 0);
        chk("t6_rst_rready", RREADY, 0);
        ar_q.delete();
        rd_q.delete();
        RVALID = 1'b0; rd_ready = 1'b1; ARREADY = 1'b1;
        @(posedge ACLK);
        #1 ARESETn = 1'b1;
        tick();
        exp_ar(1, 32'h700, 0);
        push(2'b01, mk_req(1, 32'h700, 0), '0);
        wait_ar();
        r_beat(1, RESP_OKAY, 1, 0);
        tick(3);
        chk("t6_outstanding_0", outstanding, 0);

        tick(5);
        chk("end_ar_q_empty", ar_q.size(), 0);
        chk("end_rd_q_empty", rd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_read_master_rr.md
Name: axi_read_master_rr

Overview:
Parametrised AXI3-style read master. It accepts read-request descriptors from NumSrc independent testbench/agent request FIFOs and issues them on the AR channel under round-robin arbitration. AR outputs are registered and held stable until the handshake completes. Outstanding transactions are tracked per ID, R beats are checked against the issued ARLEN, and each beat is delivered through a one-entry output register.

Parameters:
BusWidth, 32, address and data width.
tagbits, 2, ID width; 2**tagbits IDs are tracked.
NumSrc, 2, number of request sources (2..4).
FifoDepth, 4, entries per request FIFO (power of 2).
MaxOutstanding, 4, cap on concurrent accepted bursts (at most 2**tagbits).

Ports:
ACLK  in  1  clock.
ARESETn  in  1  asynchronous active-low reset.
req_wr  in  NumSrc  per-source push strobe.
req_in  in  NumSrc*ReqW  packed descriptors, source 0 in the LSBs. ReqW = tagbits+BusWidth+17. Field order MSB→LSB: id, addr, len[3:0], size[1:0], burst[1:0], lock[1:0], cache[3:0], prot[2:0].
req_full  out  NumSrc  per-source FIFO full.
ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT  out  tagbits/BusWidth/4/2/2/2/4/3  AR payload.
ARVALID  out  1;  ARREADY  in  1.
RID  in  tagbits;  RDATA  in  BusWidth;  RRESP  in  2;  RLAST  in  1;  RVALID  in  1;  RREADY  out  1.
rd_valid  out  1  captured beat valid.
rd_ready  in  1  consumer accepts beat.
rd_data  out  BusWidth;  rd_id  out  tagbits;  rd_last  out  1.
rd_err  out  1  beat flagged erroneous.
outstanding  out  $clog2(MaxOutstanding+1)  accepted bursts not yet completed.

Behaviour:
- Reset (async, takes effect immediately, including mid-burst): all outputs 0; FIFOs empty; rr_ptr=0; busy/beat tables cleared; AR FSM=IDLE.
- Request FIFOs: push ignored when full (no overwrite). Simultaneous push and pop on a full FIFO is allowed.
- AR FSM has two states, IDLE and ISSUE.
  - IDLE: scan sources starting at rr_ptr, wrapping modulo NumSrc. A source is eligible when its FIFO is non-empty, busy[head.id]==0, and outstanding<MaxOutstanding. The first eligible source wins: its FIFO pops, the AR registers load from its head, ARVALID<=1, and the FSM goes to ISSUE. First ARVALID appears 1 cycle after the descriptor becomes eligible.
  - ISSUE: the AR payload and ARVALID are held stable. On ARREADY: ARVALID<=0, busy[ARID]<=1, exp_len[ARID]<=ARLEN, beat[ARID]<=0, outstanding+1, rr_ptr<=granted+1 (mod NumSrc), FSM→IDLE. Minimum spacing between back-to-back issues is 2 cycles.
  - An ineligible head (busy ID) does not block other sources.
- R channel:
  - RREADY = !rd_valid || rd_ready.
  - On RVALID&&RREADY: capture rd_data/rd_id/rd_last into the output register, rd_valid<=1, beat[RID]+1.
  - rd_err=1 when any of the following holds: RRESP!=0; busy[RID]==0; RLAST asserted with beat!=exp_len; or beat==exp_len without RLAST.
  - On RLAST, busy[RID]<=0 and outstanding decrements, whether or not the beat is erroneous.
  - rd_valid clears on rd_ready when no new beat is captured in the same cycle.
- Same-cycle AR accept and RLAST completion leave outstanding unchanged. If both target the same ID, completion is processed first and the new issue then sets busy.
- R beats may interleave across IDs.

Decomposition:
- Package axi_rm_pkg holds: field offset/width localparams for the descriptor, the ReqW function, and RRESP codes (OKAY=0, SLVERR=2, DECERR=3).
- One sub-module, req_fifo: parametrised show-ahead synchronous FIFO with count-based full/empty, instantiated NumSrc times.
- The arbiter and ID scoreboard stay inline.

Test Plan:
- Single issue: push src0 {id=1, addr=0x100, len=3}, ARREADY tied 1 → ARVALID 1 cycle later with ARADDR=0x100, ARLEN=3. Return 4 beats with RLAST on beat 4 → 4 rd_valid beats, rd_err=0, outstanding returns 0.
- Round-robin: preload src0 with ids 0,1 and src1 with ids 2,3 → AR order is id 0,2,1,3.
- Stability under backpressure: hold ARREADY=0 for 5 cycles → ARVALID and the payload stay constant; accept on cycle 6.
- ID conflict and cap: src0 head id=2 while id 2 is busy, src1 head id=3 → id=3 issues first. With MaxOutstanding=4 and 4 bursts open, no ARVALID until an RLAST arrives.
- Errors: RLAST on beat 2 of a len=3 burst → rd_err=1 and busy cleared. RRESP=2 on a beat → rd_err=1. Unsolicited RID → rd_err=1.
- Reset mid-burst: assert ARESETn=0 during beat 2 → ARVALID, rd_valid and outstanding read 0 immediately; after release, a new request issues normally.
